// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (core / DMA) arbiter onto a single-port data memory,
//            with read-data return routing and core stall generation.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int CORE_PRIO = 1,
    parameter int MAX_WAIT  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);
    localparam logic       C_OWNER_C  = 1'b0;
    localparam logic       C_OWNER_D  = 1'b1;

    logic w_tie_to_d;
    logic w_c_win;
    logic w_d_win;
    logic r_rd_pend;
    logic r_rd_owner;

    generate
        if (CORE_PRIO != 0) begin : g_prio_core
            logic [3:0] r_wait_cnt;

            // D is starved only while it keeps requesting and losing.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_wait_cnt <= 4'd0;
                end else if (!d_req || w_d_win) begin
                    r_wait_cnt <= 4'd0;
                end else if (r_wait_cnt != C_MAX_WAIT) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end

            assign w_tie_to_d = (r_wait_cnt == C_MAX_WAIT);
        end else begin : g_prio_rr
            logic r_last_owner;

            // Resets to D so that the first tie after reset goes to the core.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_last_owner <= C_OWNER_D;
                end else if (w_c_win) begin
                    r_last_owner <= C_OWNER_C;
                end else if (w_d_win) begin
                    r_last_owner <= C_OWNER_D;
                end
            end

            assign w_tie_to_d = (r_last_owner == C_OWNER_C);
        end
    endgenerate

    always_comb begin
        w_c_win = ~reset & c_req & (~d_req | ~w_tie_to_d);
        w_d_win = ~reset & d_req & (~c_req |  w_tie_to_d);
    end

    // AND-OR muxing keeps an idle port's (possibly undriven) bundle off the bus.
    always_comb begin
        m_en    = w_c_win | w_d_win;
        m_we    = (w_c_win & c_we) | (w_d_win & d_we);
        m_addr  = ({AW{w_c_win}} & c_addr)  | ({AW{w_d_win}} & d_addr);
        m_wdata = ({DW{w_c_win}} & c_wdata) | ({DW{w_d_win}} & d_wdata);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= C_OWNER_C;
        end else begin
            r_rd_pend  <= m_en & ~m_we;
            r_rd_owner <= w_d_win ? C_OWNER_D : C_OWNER_C;
        end
    end

    always_comb begin
        c_gnt    = w_c_win;
        d_gnt    = w_d_win;
        c_stall  = c_req & ~w_c_win;
        c_rvalid = r_rd_pend & (r_rd_owner == C_OWNER_C);
        d_rvalid = r_rd_pend & (r_rd_owner == C_OWNER_D);
        c_rdata  = {DW{c_rvalid}} & m_rdata;
        d_rdata  = {DW{d_rvalid}} & m_rdata;
    end

endmodule
`default_nettype wire
